// File: rtl/hdx_wire_ctrl.sv
// Half-duplex single-wire controller: sends one UART-framed command byte through a
// clocked bidirectional pad buffer, releases the wire, optionally receives one reply byte.
// Latency: DONE at cycle 2+10*DIV after START (TX only); START is ignored while busy (no queueing).
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   START             begin transaction, sampled only in IDLE
//   TX_DATA, RX_EXPECT command byte / response-wanted flag, captured with START
//   PAD_O             registered wire value from the pad buffer
//   PAD_I, PAD_EN     pad buffer data and output enable (PAD_EN=1 drives the wire)
//   PAD_CE            pad buffer clock enable, 1 from the first clock after reset
//   BUSY, DONE        transaction in progress / one-cycle completion pulse
//   ERR, RX_DATA      00 ok, 01 RX timeout, 10 RX framing; last good received byte
module hdx_wire_ctrl #(
  parameter int DIV     = 4,   // CLK cycles per bit, >= 2
  parameter int TURN    = 2,   // bit periods of wire release before hunting, >= 1
  parameter int TIMEOUT = 16   // bit periods allowed to find a start bit
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [7:0] TX_DATA,
  input  logic       RX_EXPECT,
  input  logic       PAD_O,
  output logic       PAD_I,
  output logic       PAD_EN,
  output logic       PAD_CE,
  output logic       BUSY,
  output logic       DONE,
  output logic [1:0] ERR,
  output logic [7:0] RX_DATA
);

  localparam int TO_MAX = ((TIMEOUT > TURN) ? TIMEOUT : TURN) * DIV;
  localparam int TO_W   = (TO_MAX > 1) ? $clog2(TO_MAX) : 1;
  localparam int CNT_W  = $clog2(DIV);

  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [TO_W-1:0]  TO_TURN  = TO_W'(TURN * DIV - 1);
  localparam logic [TO_W-1:0]  TO_HUNT  = TO_W'(TIMEOUT * DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_TX, S_TURN, S_HUNT, S_RX, S_FIN
  } state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit;
  logic [TO_W-1:0]  r_to;
  logic [7:0]       r_tx;
  logic             r_rxe;
  logic [7:0]       r_sh;
  logic [1:0]       r_err;
  logic [7:0]       r_rx_data;
  logic             r_ce;

  logic       w_pad_i, w_pad_en, w_busy, w_done;
  logic       w_cnt0;
  logic [9:0] w_frame;

  assign w_cnt0  = (r_cnt == '0);
  assign w_frame = {1'b1, r_tx, 1'b0};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Outputs decode straight from the state register so an async reset
  // releases the wire and drops BUSY without waiting for a clock.
  always_comb begin
    w_next   = r_state;
    w_pad_i  = 1'b1;
    w_pad_en = 1'b0;
    w_busy   = 1'b1;
    w_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (START) w_next = S_PRE;
      end
      // PAD_I=1 with the driver off loads the buffer's output register with
      // idle-high before PAD_EN rises.
      S_PRE: w_next = S_TX;
      S_TX: begin
        w_pad_en = 1'b1;
        w_pad_i  = w_frame[r_bit];
        if (w_cnt0 && r_bit == 4'd9) w_next = r_rxe ? S_TURN : S_FIN;
      end
      S_TURN: if (r_to == '0) w_next = S_HUNT;
      S_HUNT: begin
        if (!PAD_O)           w_next = S_RX;
        else if (r_to == '0)  w_next = S_FIN;
      end
      S_RX: begin
        if (w_cnt0) begin
          if (r_bit == 4'd0 && PAD_O) w_next = S_HUNT;  // start-bit glitch
          else if (r_bit == 4'd9)     w_next = S_FIN;
        end
      end
      S_FIN: begin
        w_busy = 1'b0;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt     <= '0;
      r_bit     <= '0;
      r_to      <= '0;
      r_tx      <= '0;
      r_rxe     <= 1'b0;
      r_sh      <= '0;
      r_err     <= 2'b00;
      r_rx_data <= '0;
      r_ce      <= 1'b0;
    end else begin
      r_ce <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_tx  <= TX_DATA;
            r_rxe <= RX_EXPECT;
            r_err <= 2'b00;
          end
        end
        S_PRE: begin
          r_cnt <= CNT_BIT;
          r_bit <= '0;
        end
        S_TX: begin
          if (w_cnt0) begin
            r_cnt <= CNT_BIT;
            if (r_bit == 4'd9) r_to  <= TO_TURN;
            else               r_bit <= r_bit + 4'd1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_TURN: begin
          if (r_to == '0) r_to <= TO_HUNT;
          else            r_to <= r_to - 1'b1;
        end
        // The timeout counter is frozen while a start bit is being verified
        // and resumes from where it was if that start turns out to be a glitch.
        S_HUNT: begin
          if (!PAD_O) begin
            r_cnt <= CNT_HALF;
            r_bit <= '0;
          end else if (r_to == '0) begin
            r_err <= 2'b01;
          end else begin
            r_to <= r_to - 1'b1;
          end
        end
        S_RX: begin
          if (w_cnt0) begin
            r_cnt <= CNT_BIT;
            if (r_bit == 4'd0) begin
              r_bit <= 4'd1;
            end else if (r_bit != 4'd9) begin
              r_sh  <= {PAD_O, r_sh[7:1]};  // LSB arrives first
              r_bit <= r_bit + 4'd1;
            end else if (PAD_O) begin
              r_rx_data <= r_sh;
              r_err     <= 2'b00;
            end else begin
              r_err <= 2'b10;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign PAD_I   = w_pad_i;
  assign PAD_EN  = w_pad_en;
  assign PAD_CE  = r_ce;
  assign BUSY    = w_busy;
  assign DONE    = w_done;
  assign ERR     = r_err;
  assign RX_DATA = r_rx_data;

endmodule

// File: tb/tb_hdx_wire_ctrl.sv
// Directed bench for hdx_wire_ctrl with a clocked pad-buffer model and a
// scripted far-side responder that only drives while PAD_EN=0.
module tb_hdx_wire_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [7:0] TX_DATA;
  logic       RX_EXPECT;
  logic       PAD_O;
  logic       PAD_I, PAD_EN, PAD_CE, BUSY, DONE;
  logic [1:0] ERR;
  logic [7:0] RX_DATA;

  int checks = 0;
  int errors = 0;
  int conflicts = 0;

  // far-side model drive and pad buffer model
  logic m_drv = 1'b0;
  logic m_val = 1'b1;
  logic r_buf = 1'b1;
  logic r_pado = 1'b1;
  logic w_wire;

  assign w_wire = PAD_EN ? r_buf : (m_drv ? m_val : 1'b1);
  assign PAD_O  = r_pado;

  always @(posedge CLK) begin
    if (PAD_CE) begin
      r_buf  <= PAD_I;
      r_pado <= w_wire;
    end
  end

  always #5 CLK = ~CLK;

  hdx_wire_ctrl #(.DIV(4), .TURN(2), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .TX_DATA(TX_DATA), .RX_EXPECT(RX_EXPECT),
    .PAD_O(PAD_O), .PAD_I(PAD_I), .PAD_EN(PAD_EN), .PAD_CE(PAD_CE), .BUSY(BUSY),
    .DONE(DONE), .ERR(ERR), .RX_DATA(RX_DATA)
  );

  // One transaction; cycle c is the c-th period after the START edge.
  // s_cyc: first cycle of the responder frame (-1 none); g_cyc: 1-cycle low glitch (-1 none).
  task automatic do_txn(input logic [7:0] d, input logic rxe,
                        input int s_cyc, input logic [7:0] rd, input logic rstop,
                        input int g_cyc,
                        output int done_cyc, output int done_cnt, output int en_cnt,
                        output int bit_err, output logic [1:0] err_at_done,
                        output logic busy_at_done);
    logic [9:0] fr;
    logic [9:0] rf;
    fr = {1'b1, d, 1'b0};
    rf = {rstop, rd, 1'b0};
    done_cyc = -1; done_cnt = 0; en_cnt = 0; bit_err = 0;
    err_at_done = 2'bxx; busy_at_done = 1'bx;
    @(negedge CLK);
    START = 1'b1; TX_DATA = d; RX_EXPECT = rxe;
    @(posedge CLK);
    for (int c = 1; c <= 250; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        START = 1'b0;
        if (PAD_EN !== 1'b0 || PAD_I !== 1'b1 || BUSY !== 1'b1) bit_err++;
      end
      if (PAD_EN === 1'b1) en_cnt++;
      if (c >= 2 && c <= 41 && (PAD_EN !== 1'b1 || PAD_I !== fr[(c-2)/4])) bit_err++;
      if (DONE === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c; err_at_done = ERR; busy_at_done = BUSY;
        end
      end
      if (s_cyc >= 0 && c >= s_cyc && c < s_cyc + 40) begin
        m_drv = 1'b1; m_val = rf[(c - s_cyc) / 4];
      end else if (c == g_cyc) begin
        m_drv = 1'b1; m_val = 1'b0;
      end else begin
        m_drv = 1'b0; m_val = 1'b1;
      end
      if (m_drv && PAD_EN === 1'b1) conflicts++;
      if (done_cyc > 0 && c >= done_cyc + 2) break;
    end
    m_drv = 1'b0; m_val = 1'b1;
  endtask

  task automatic test_reset;
    RST = 1'b1; START = 1'b0; TX_DATA = 8'h00; RX_EXPECT = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (PAD_I !== 1'b1)    begin errors++; $display("FAIL rst_pad_i got %b want 1", PAD_I); end
    checks++; if (PAD_EN !== 1'b0)   begin errors++; $display("FAIL rst_pad_en got %b want 0", PAD_EN); end
    checks++; if (PAD_CE !== 1'b0)   begin errors++; $display("FAIL rst_pad_ce got %b want 0", PAD_CE); end
    checks++; if (BUSY !== 1'b0)     begin errors++; $display("FAIL rst_busy got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0)     begin errors++; $display("FAIL rst_done got %b want 0", DONE); end
    checks++; if (ERR !== 2'b00)     begin errors++; $display("FAIL rst_err got %b want 00", ERR); end
    checks++; if (RX_DATA !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %h want 00", RX_DATA); end
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (PAD_CE !== 1'b1)   begin errors++; $display("FAIL ce_after_rst got %b want 1", PAD_CE); end
  endtask

  task automatic test_tx_only;
    int dc, dn, en, be; logic [1:0] e; logic b;
    do_txn(8'hA5, 1'b0, -1, 8'h00, 1'b1, -1, dc, dn, en, be, e, b);
    checks++; if (be != 0)     begin errors++; $display("FAIL tx_bits got %0d bad cycles want 0", be); end
    checks++; if (en != 40)    begin errors++; $display("FAIL tx_en_len got %0d want 40", en); end
    checks++; if (dc != 42)    begin errors++; $display("FAIL tx_done_cycle got %0d want 42", dc); end
    checks++; if (dn != 1)     begin errors++; $display("FAIL tx_done_count got %0d want 1", dn); end
    checks++; if (e !== 2'b00) begin errors++; $display("FAIL tx_err got %b want 00", e); end
    checks++; if (b !== 1'b0)  begin errors++; $display("FAIL tx_busy_at_done got %b want 0", b); end
  endtask

  task automatic test_full_rx;
    int dc, dn, en, be; logic [1:0] e; logic b;
    do_txn(8'h12, 1'b1, 52, 8'h3C, 1'b1, -1, dc, dn, en, be, e, b);
    checks++; if (be != 0 || en != 40) begin errors++; $display("FAIL full_tx got bad=%0d en=%0d want 0/40", be, en); end
    checks++; if (dc != 92)     begin errors++; $display("FAIL full_done_cycle got %0d want 92", dc); end
    checks++; if (dn != 1)      begin errors++; $display("FAIL full_done_count got %0d want 1", dn); end
    checks++; if (e !== 2'b00)  begin errors++; $display("FAIL full_err got %b want 00", e); end
    checks++; if (RX_DATA !== 8'h3C) begin errors++; $display("FAIL full_rx_data got %h want 3c", RX_DATA); end
  endtask

  task automatic test_timeout;
    int dc, dn, en, be; logic [1:0] e; logic b;
    do_txn(8'h77, 1'b1, -1, 8'h00, 1'b1, -1, dc, dn, en, be, e, b);
    checks++; if (dc != 114)    begin errors++; $display("FAIL to_done_cycle got %0d want 114", dc); end
    checks++; if (e !== 2'b01)  begin errors++; $display("FAIL to_err got %b want 01", e); end
    checks++; if (RX_DATA !== 8'h3C) begin errors++; $display("FAIL to_rx_data got %h want 3c", RX_DATA); end
    checks++; if (ERR !== 2'b01) begin errors++; $display("FAIL to_err_held got %b want 01", ERR); end
  endtask

  task automatic test_framing;
    int dc, dn, en, be; logic [1:0] e; logic b;
    do_txn(8'h01, 1'b1, 52, 8'h81, 1'b0, -1, dc, dn, en, be, e, b);
    checks++; if (dc != 92)     begin errors++; $display("FAIL frm_done_cycle got %0d want 92", dc); end
    checks++; if (e !== 2'b10)  begin errors++; $display("FAIL frm_err got %b want 10", e); end
    checks++; if (RX_DATA !== 8'h3C) begin errors++; $display("FAIL frm_rx_data got %h want 3c", RX_DATA); end
  endtask

  task automatic test_glitch;
    int dc, dn, en, be; logic [1:0] e; logic b;
    do_txn(8'h02, 1'b1, 60, 8'h96, 1'b1, 52, dc, dn, en, be, e, b);
    checks++; if (dc != 100)    begin errors++; $display("FAIL gl_done_cycle got %0d want 100", dc); end
    checks++; if (e !== 2'b00)  begin errors++; $display("FAIL gl_err got %b want 00", e); end
    checks++; if (RX_DATA !== 8'h96) begin errors++; $display("FAIL gl_rx_data got %h want 96", RX_DATA); end
  endtask

  task automatic test_reset_mid_tx;
    int dc, dn, en, be; logic [1:0] e; logic b;
    @(negedge CLK);
    START = 1'b1; TX_DATA = 8'h00; RX_EXPECT = 1'b0;
    @(posedge CLK);
    for (int c = 1; c <= 19; c++) begin
      @(negedge CLK);
      if (c == 1) START = 1'b0;
    end
    // cycle 19 is inside data bit 3 (frame bit 4), which is 0 for 0x00
    checks++; if (PAD_EN !== 1'b1 || PAD_I !== 1'b0) begin errors++; $display("FAIL mid_pre en=%b i=%b want 1/0", PAD_EN, PAD_I); end
    RST = 1'b1;
    #1;
    checks++; if (PAD_EN !== 1'b0) begin errors++; $display("FAIL mid_rst_en got %b want 0", PAD_EN); end
    checks++; if (PAD_I !== 1'b1)  begin errors++; $display("FAIL mid_rst_i got %b want 1", PAD_I); end
    checks++; if (BUSY !== 1'b0)   begin errors++; $display("FAIL mid_rst_busy got %b want 0", BUSY); end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    do_txn(8'h5A, 1'b0, -1, 8'h00, 1'b1, -1, dc, dn, en, be, e, b);
    checks++; if (be != 0 || en != 40) begin errors++; $display("FAIL post_rst_tx got bad=%0d en=%0d want 0/40", be, en); end
    checks++; if (dc != 42)     begin errors++; $display("FAIL post_rst_done got %0d want 42", dc); end
    checks++; if (e !== 2'b00)  begin errors++; $display("FAIL post_rst_err got %b want 00", e); end
  endtask

  task automatic test_back_to_back;
    int d1, d2, nd;
    logic b43, b44, en45, en30;
    d1 = -1; d2 = -1; nd = 0; b43 = 1'bx; b44 = 1'bx; en45 = 1'bx; en30 = 1'bx;
    @(negedge CLK);
    START = 1'b1; TX_DATA = 8'hC3; RX_EXPECT = 1'b0;
    @(posedge CLK);
    for (int c = 1; c <= 90; c++) begin
      @(negedge CLK);
      if (DONE === 1'b1) begin
        nd++;
        if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
      end
      if (c == 30) en30 = PAD_EN;
      if (c == 43) b43 = BUSY;
      if (c == 44) b44 = BUSY;
      if (c == 45) en45 = PAD_EN;
      if (d2 > 0) START = 1'b0;
    end
    START = 1'b0;
    checks++; if (d1 != 42)     begin errors++; $display("FAIL b2b_done1 got %0d want 42", d1); end
    checks++; if (en30 !== 1'b1) begin errors++; $display("FAIL b2b_no_restart en got %b want 1", en30); end
    checks++; if (b43 !== 1'b0 || b44 !== 1'b1) begin errors++; $display("FAIL b2b_idle_gap busy43=%b busy44=%b want 0/1", b43, b44); end
    checks++; if (en45 !== 1'b1) begin errors++; $display("FAIL b2b_tx2_en got %b want 1", en45); end
    checks++; if (d2 != 85)     begin errors++; $display("FAIL b2b_done2 got %0d want 85", d2); end
    checks++; if (nd != 2)      begin errors++; $display("FAIL b2b_done_count got %0d want 2", nd); end
  endtask

  initial begin
    test_reset();
    test_tx_only();
    test_full_rx();
    test_timeout();
    test_framing();
    test_glitch();
    test_reset_mid_tx();
    test_back_to_back();
    checks++;
    if (conflicts != 0) begin errors++; $display("FAIL wire_conflict got %0d want 0", conflicts); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdx_wire_ctrl.md
# hdx_wire_ctrl

Half-duplex single-wire transaction controller that drives the near side of the team's clocked bidirectional pad buffer. It sends one UART-framed command byte out through the pad, then releases the wire for a turnaround gap. Optionally it then receives one framed response byte, sampled from the buffer's registered input. It sits between a register-level host (start/data/done) and the pad buffer's I/EN/CE/O pins.

## Interface
- DIV, 4: CLK cycles per bit period; legal range ≥ 2.
- TURN, 2: bit periods the wire is released between TX stop bit and start of RX hunt.
- TIMEOUT, 16: bit periods allowed in RX hunt before a timeout error.
- CLK in 1: clock, rising edge.
- RST in 1: reset, asynchronous, active-high.
- START in 1: begin transaction; sampled only in IDLE.
- TX_DATA in 8: command byte; captured on the accepted START.
- RX_EXPECT in 1: 1 = receive response after TX; captured with START.
- PAD_O in 1: registered pad value from the buffer.
- PAD_I out 1: data to the buffer's registered driver.
- PAD_EN out 1: buffer output enable; 1 drives the wire.
- PAD_CE out 1: buffer clock enable.
- BUSY out 1: transaction in progress.
- DONE out 1: one-cycle completion pulse.
- ERR out 2: 00 ok, 01 RX timeout, 10 RX framing error; valid with DONE, held until next START.
- RX_DATA out 8: received byte; updated only on an ok RX completion, held otherwise.

## Operation
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. The idle wire is high, supplied by an external pull-up.
- Reset values: PAD_I=1, PAD_EN=0, PAD_CE=0, BUSY=0, DONE=0, ERR=00, RX_DATA=0x00. PAD_CE goes to 1 on the first clock after RST deasserts and stays 1.
- States:
  - IDLE: wait for START.
  - PRE: one cycle with PAD_I=1, PAD_EN=0. This preloads the buffer's output register so enabling never glitches an old value onto the wire.
  - TX: 10 bits, each DIV cycles, with PAD_EN=1 throughout.
  - TURN: TURN×DIV cycles with PAD_EN=0.
  - HUNT: wait for PAD_O=0, for at most TIMEOUT×DIV cycles.
  - RX: receive the response frame.
  - FIN: one cycle with DONE=1, then return to IDLE.
- Transitions:
  - IDLE→PRE on START=1.
  - PRE→TX.
  - TX→FIN if RX_EXPECT=0, else TX→TURN.
  - TURN→HUNT.
  - HUNT→RX on PAD_O=0.
  - HUNT→FIN with ERR=01 on timeout.
  - RX→FIN.
- RX sampling: start is detected at cycle t. Sample PAD_O at t+DIV/2 (integer divide).
  - If the sample is 1, treat it as a glitch and return to HUNT. The timeout counter is not reset.
  - Otherwise sample the data bits at t+DIV/2+k×DIV for k=1..8 and the stop bit at k=9.
  - Stop bit 0 → ERR=10 and RX_DATA unchanged. Stop bit 1 → ERR=00 and RX_DATA loaded.
- Bit timing uses one down-counter reloaded to DIV-1 per bit, plus a 4-bit bit index. The timeout counter is sized for TIMEOUT×DIV.
- START while BUSY=1 is ignored; no queueing.
- PAD_EN is never 1 outside TX, so the controller never drives during TURN, HUNT or RX.

## Timing
- START accepted at edge 0 → BUSY=1 from cycle 1; PRE occupies cycle 1.
- TX occupies cycles 2 .. 1+10×DIV.
- The wire lags PAD_I by one cycle because of the buffer register. PAD_EN is combinational in the buffer, so the wire goes Z in the same cycle PAD_EN drops.
- RX_EXPECT=0: DONE in cycle 2+10×DIV (42 at DIV=4). BUSY falls in the same cycle as DONE.
- RX_EXPECT=1: TURN starts at cycle 2+10×DIV; HUNT starts after TURN×DIV cycles.
- ERR and RX_DATA update in the FIN cycle.
- Async RST mid-operation: all outputs take their reset values immediately, including PAD_EN=0 (wire released). After RST deasserts the controller is in IDLE.
- START asserted in the DONE cycle is ignored. START in the following IDLE cycle is accepted.

## Test plan
- TX only, DIV=4, TX_DATA=0xA5, RX_EXPECT=0:
  - PAD_I sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - PAD_EN=1 for exactly 40 cycles.
  - DONE pulses at cycle 42 with ERR=00.
- Full transaction: a bench model answers 0x3C after the turnaround (model drives the wire only while PAD_EN=0) → RX_DATA=0x3C, ERR=00, DONE pulses once.
- No response, TIMEOUT=16, DIV=4 → HUNT lasts 64 cycles, then DONE with ERR=01 and RX_DATA unchanged.
- Response with stop bit forced 0 → ERR=10, RX_DATA keeps its prior value. A 1-cycle low glitch during HUNT is rejected, and the following valid frame is received correctly.
- RST pulsed mid-TX (bit 4) → PAD_EN=0, PAD_I=1, BUSY=0 in the same cycle. A subsequent START runs a clean frame.
- START held high through a transaction → second frame starts exactly one IDLE cycle after DONE. A START pulse while BUSY=1 is ignored.
